// File: rtl/rv6_pkg.sv
// Shared rv6 pipeline definitions: reset vector, bubble encoding and the
// fetch FSM state / fetch pair types used by the ifetch slice.
package rv6_pkg;

  localparam logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ir;
  } fetch_pair_t;

endpackage

// File: rtl/ifq.sv
// Two-entry {pc, ir} FIFO between instruction memory responses and the
// ifetch output registers. Flush empties it in one cycle.
module ifq
  import rv6_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_pair_t push_data,
  output fetch_pair_t head,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count
);

  fetch_pair_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_push;
  logic        do_pop;

  // A pop frees its slot before the same-cycle push lands, so push on full is legal with pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    full    = (count == 2'd2);
    empty   = (count == 2'd0);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch.sv
// rv6 instruction fetch: PC/FSM, one-outstanding imem request, 2-entry
// instruction queue and registered {pc, ir} outputs toward predecode.
module ifetch
  import rv6_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [63:0]  br_addr,
  output logic         imem_req,
  output logic [63:0]  imem_addr,
  input  logic         imem_ack,
  input  logic         imem_rdy,
  input  logic [31:0]  imem_data,
  output logic [63:0]  pc_out,
  output logic [31:0]  ir_out,
  output fetch_state_e dbg_state
);

  // imem handshake: imem_req/imem_addr hold stable until the cycle with
  // imem_ack (request accepted at that edge, never withdrawn); imem_rdy marks
  // the single in-order response carrying imem_data.
  fetch_state_e state;
  logic [63:0]  fetch_pc;
  logic [63:0]  fetch_pc_next;
  logic [63:0]  br_target;
  logic         drop;

  fetch_pair_t  resp;
  fetch_pair_t  q_head;
  logic         q_full;
  logic         q_empty;
  logic [1:0]   q_count;
  logic [1:0]   q_count_next;
  logic         resp_keep;
  logic         pop;
  logic         bypass;
  logic         push;
  logic         credit;

  always_comb begin
    br_target = br_addr & ~64'd3;
    resp.pc   = imem_addr;
    resp.ir   = imem_data;
    resp_keep = (state == WAIT) && imem_rdy && !drop && !br_taken;
    pop       = !br_taken && !stall && !q_empty;
    bypass    = !br_taken && !stall && q_empty && resp_keep;
    push      = resp_keep && !bypass && (!q_full || pop);
    q_count_next = br_taken ? 2'd0 : (q_count + 2'(push) - 2'(pop));
    // Credit is judged on the occupancy after this edge, with nothing outstanding.
    credit    = (q_count_next < 2'd2);
    // A stale request (drop set while in REQ) must not advance the corrected PC.
    if (br_taken)
      fetch_pc_next = br_target;
    else if (state == REQ && imem_ack && !drop)
      fetch_pc_next = fetch_pc + 64'd4;
    else
      fetch_pc_next = fetch_pc;
  end

  ifq u_ifq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (br_taken),
    .push_data (resp),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_VECTOR;
      drop      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= 64'd0;
    end else begin
      fetch_pc <= fetch_pc_next;
      if (br_taken && (state == REQ || (state == WAIT && !imem_rdy)))
        drop <= 1'b1;
      else if (state == WAIT && imem_rdy)
        drop <= 1'b0;
      case (state)
        IDLE: begin
          if (credit) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc_next & ~64'd3;
          end
        end
        REQ: begin
          if (imem_ack) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rdy) begin
            if (credit) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc_next & ~64'd3;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out <= RESET_VECTOR;
      ir_out <= NOP;
    end else if (br_taken) begin
      pc_out <= br_target;
      ir_out <= NOP;
    end else if (!stall) begin
      if (pop) begin
        pc_out <= q_head.pc;
        ir_out <= q_head.ir;
      end else if (bypass) begin
        pc_out <= resp.pc;
        ir_out <= resp.ir;
      end else begin
        ir_out <= NOP;
      end
    end
  end

  assign dbg_state = state;

endmodule
